// File: rtl/instruction_fetch.sv
// Instruction fetch: single-outstanding request to instruction memory feeding a
// 2-entry instruction buffer, with branch redirect and stale-response dropping.
`timescale 1ns/1ps

module instruction_fetch #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int          DEPTH    = 2
) (
   input  logic        Clock,
   input  logic        ResetN,
   output logic        IMemReq,
   output logic [15:0] IMemAddr,
   input  logic        IMemAck,
   input  logic [15:0] IMemData,
   input  logic        BranchTaken,
   input  logic [15:0] BranchTarget,
   input  logic        InstrReady,
   output logic        InstrValid,
   output logic [15:0] Instr,
   output logic [15:0] InstrPC,
   output logic [3:0]  Opcode
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } fetchStateT;

   fetchStateT       state, nextState;
   logic [15:0]      pc;
   logic [15:0]      staleAddr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] countAfter;
   logic [PTR_W-1:0] rdPtr, wrPtr;
   logic [15:0]      bufInstr [DEPTH];
   logic [15:0]      bufPC    [DEPTH];
   logic             doPush;
   logic             doPop;

   // A branch flushes the buffer, so both the push and the occupancy outlook yield to it.
   assign doPop      = (count != '0) && InstrReady;
   assign doPush     = (state == REQ) && IMemAck && !BranchTaken;
   assign countAfter = BranchTaken ? '0 : (count + CNT_W'(doPush) - CNT_W'(doPop));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) state <= IDLE;
      else         state <= nextState;
   end

   always_comb begin
      // NOTE: default to holding state so no path through the case infers a latch.
      nextState = state;
      unique case (state)
         IDLE: if (countAfter < FULL_COUNT) nextState = REQ;
         REQ: begin
            if (BranchTaken)  nextState = IMemAck ? IDLE : DROP;
            else if (IMemAck) nextState = (countAfter < FULL_COUNT) ? REQ : IDLE;
         end
         DROP: if (IMemAck) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // In DROP the PC already points at the branch target, so the address of the
   // abandoned request is presented from its own register until it is acked.
   always_comb begin
      IMemReq  = (state != IDLE);
      IMemAddr = (state == DROP) ? staleAddr : pc;
   end

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         pc        <= RESET_PC;
         staleAddr <= RESET_PC;
      end else begin
         if (BranchTaken) pc <= BranchTarget;
         else if (doPush) pc <= pc + 16'd1;
         if ((state == REQ) && BranchTaken && !IMemAck) staleAddr <= pc;
      end
   end

   // NOTE: the buffer entries are reset because the head drives Instr/InstrPC,
   // which must read zero while in reset.
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         count <= '0;
         rdPtr <= '0;
         wrPtr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            bufInstr[i] <= '0;
            bufPC[i]    <= '0;
         end
      end else if (BranchTaken) begin
         count <= '0;
         rdPtr <= '0;
         wrPtr <= '0;
      end else begin
         if (doPush) begin
            bufInstr[wrPtr] <= IMemData;
            bufPC[wrPtr]    <= pc;
            wrPtr           <= wrPtr + PTR_W'(1);
         end
         if (doPop) rdPtr <= rdPtr + PTR_W'(1);
         count <= countAfter;
      end
   end

   assign InstrValid = (count != '0);
   assign Instr      = bufInstr[rdPtr];
   assign InstrPC    = bufPC[rdPtr];
   assign Opcode     = Instr[15:12];

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: memory model, scoreboard of fetched
// PCs, and a second instance with RESET_PC=16'hFFFF for PC wrap-around.
`timescale 1ns/1ps

module tb_instruction_fetch;

   logic        Clock = 1'b0;
   logic        ResetN;
   logic        IMemAck;
   logic        BranchTaken;
   logic [15:0] BranchTarget;
   logic        InstrReady;

   logic        IMemReq,  IMemReq2;
   logic [15:0] IMemAddr, IMemAddr2;
   logic [15:0] IMemData, IMemData2;
   logic        InstrValid, InstrValid2;
   logic [15:0] Instr, Instr2;
   logic [15:0] InstrPC, InstrPC2;
   logic [3:0]  Opcode, Opcode2;

   int          testsRun  = 0;
   int          failCount = 0;
   logic [15:0] sb [$];
   logic [15:0] a2;

   always #5 Clock = ~Clock;

   function automatic logic [15:0] memWord(input logic [15:0] a);
      return {a[3:0] ^ 4'h9, a[15:4] ^ 12'h3C5};
   endfunction

   assign IMemData  = memWord(IMemAddr);
   assign IMemData2 = memWord(IMemAddr2);

   instruction_fetch #(.RESET_PC(16'h0000), .DEPTH(2)) dut (
      .Clock(Clock), .ResetN(ResetN),
      .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemAck(IMemAck), .IMemData(IMemData),
      .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
      .InstrReady(InstrReady), .InstrValid(InstrValid),
      .Instr(Instr), .InstrPC(InstrPC), .Opcode(Opcode)
   );

   instruction_fetch #(.RESET_PC(16'hFFFF), .DEPTH(2)) dut2 (
      .Clock(Clock), .ResetN(ResetN),
      .IMemReq(IMemReq2), .IMemAddr(IMemAddr2), .IMemAck(IMemAck), .IMemData(IMemData2),
      .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
      .InstrReady(InstrReady), .InstrValid(InstrValid2),
      .Instr(Instr2), .InstrPC(InstrPC2), .Opcode(Opcode2)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         failCount++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkBit(input string tag, input logic obs, input logic exp);
      testsRun++;
      assert (obs === exp) else begin
         failCount++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkBit({tag, "_req"},   IMemReq, 1'b0);
      check   ({tag, "_addr"},  IMemAddr, 16'h0000);
      checkBit({tag, "_valid"}, InstrValid, 1'b0);
      check   ({tag, "_instr"}, Instr, 16'h0000);
      check   ({tag, "_pc"},    InstrPC, 16'h0000);
      check   ({tag, "_op"},    16'(Opcode), 16'h0000);
   endtask

   // One clock cycle: drive inputs, check outputs against the expectations,
   // maintain the scoreboard, then advance to just after the next rising edge.
   task automatic cycle(input logic ack, input logic ready, input logic br,
                        input logic [15:0] tgt, input logic expReq,
                        input logic [15:0] expAddr, input logic expPush,
                        input logic expValid);
      logic [15:0] head;
      IMemAck      = ack;
      InstrReady   = ready;
      BranchTaken  = br;
      BranchTarget = tgt;
      #1;
      checkBit("req", IMemReq, expReq);
      if (expReq) check("addr", IMemAddr, expAddr);
      checkBit("valid", InstrValid, expValid);
      if (expValid && ready) begin
         testsRun++;
         assert (sb.size() != 0) else begin
            failCount++;
            $error("FAIL sb_underflow: observed pop with %0d queued expected at least 1", sb.size());
         end
         if (sb.size() != 0) begin
            head = sb.pop_front();
            check("instr_pc", InstrPC, head);
            check("instr",    Instr, memWord(head));
            check("opcode",   16'(Opcode), 16'(head[3:0] ^ 4'h9));
         end
      end
      if (br) sb.delete();
      if (expPush && !br) sb.push_back(expAddr);
      @(posedge Clock);
      #1;
   endtask

   task automatic doReset();
      ResetN      = 1'b0;
      IMemAck     = 1'b0;
      InstrReady  = 1'b0;
      BranchTaken = 1'b0;
      sb.delete();
      @(posedge Clock);
      #1;
      ResetN = 1'b1;
      @(posedge Clock);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      ResetN       = 1'b0;
      IMemAck      = 1'b0;
      BranchTaken  = 1'b0;
      BranchTarget = 16'h0000;
      InstrReady   = 1'b0;
      @(posedge Clock);
      @(posedge Clock);
      #1;
      checkResetOutputs("rst");
      check("rst2_addr", IMemAddr2, 16'hFFFF);
      ResetN = 1'b1;
      @(posedge Clock);
      #1;

      // Streaming from reset; dut2 streams from FFFF and wraps to 0000.
      for (int k = 0; k < 6; k++) begin
         a2 = 16'hFFFF + 16'(k);
         if (k < 3) begin
            check("wrap_addr", IMemAddr2, a2);
            if (k >= 1) begin
               check("wrap_pc",    InstrPC2, a2 - 16'd1);
               check("wrap_instr", Instr2, memWord(a2 - 16'd1));
            end
         end
         cycle(1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 16'(k), 1'b1, k >= 1);
      end

      // Backpressure: two pushes fill the buffer, then one slot opens.
      doReset();
      cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'd0, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'd1, 1'b1, 1'b1);
      cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'd0, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'd0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'd2, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'd2, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'd0, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'd0, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'd3, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'd3, 1'b0, 1'b0);

      // Redirect while a request is pending, with a pop and a second branch in DROP.
      doReset();
      for (int k = 0; k < 5; k++)
         cycle(1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 16'(k), 1'b1, k >= 1);
      cycle(1'b0, 1'b1, 1'b1, 16'h0030, 1'b1, 16'd5, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 16'h0040, 1'b1, 16'd5, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 16'h0,    1'b1, 16'd5, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 16'h0,    1'b1, 16'd5, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 16'h0,    1'b0, 16'd0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 16'h0,    1'b1, 16'h0040, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 16'h0,    1'b1, 16'h0041, 1'b0, 1'b1);

      // Redirect coinciding with the ack: data dropped, refetch at the target.
      doReset();
      cycle(1'b1, 1'b1, 1'b1, 16'h1234, 1'b1, 16'd0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 16'h0,    1'b0, 16'd0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 16'h0,    1'b1, 16'h1234, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 16'h0,    1'b1, 16'h1235, 1'b0, 1'b1);

      // Asynchronous reset while in DROP; a late ack must not push.
      doReset();
      cycle(1'b1, 1'b0, 1'b0, 16'h0,    1'b1, 16'd0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 16'h0,    1'b1, 16'd1, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 16'h0200, 1'b1, 16'd1, 1'b0, 1'b1);
      BranchTaken = 1'b0;
      #1;
      checkBit("drop_req", IMemReq, 1'b1);
      check("drop_addr", IMemAddr, 16'd1);
      #2;
      ResetN = 1'b0;
      #1;
      checkResetOutputs("async_rst");
      IMemAck = 1'b1;
      @(posedge Clock);
      #1;
      checkBit("late_ack_valid", InstrValid, 1'b0);
      checkBit("late_ack_req", IMemReq, 1'b0);
      ResetN = 1'b1;
      @(posedge Clock);
      #1;
      cycle(1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 16'd0, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'd1, 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
